// File: rtl/bist_ctrl.sv
// bist_ctrl: LFSR/MISR built-in self-test controller between chip pins and the CUT.
// Latency: bistdone rises 2+NUM_PATTERNS+FLUSH_CYCLES edges after a run starts from IDLE.
// Backpressure: none; dropping bistmode aborts or releases the run on the next edge.
module bist_ctrl #(
  parameter int              PI_W         = 35,
  parameter int              PO_W         = 49,
  parameter int              NUM_PATTERNS = 2000,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [PI_W-1:0] LFSR_SEED    = PI_W'(1),
  parameter logic [PI_W-1:0] LFSR_TAPS    = {1'b1, {(PI_W-3){1'b0}}, 2'b10},
  parameter logic [PO_W-1:0] MISR_TAPS    = {1'b1, {(PO_W-10){1'b0}}, 9'h100},
  parameter logic [PO_W-1:0] GOLDEN_SIG   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bistmode,
  input  logic [PI_W-1:0] pi,
  input  logic [PO_W-1:0] cut_po,
  output logic [PI_W-1:0] cut_pi,
  output logic            cut_rst,
  output logic [PO_W-1:0] signature,
  output logic            bistdone,
  output logic            bistpass
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [PI_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;

  // Pattern counter sized so NUM_PATTERNS-1 is always representable.
  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
  // Flush counter kept at least one bit wide even when flushing is disabled.
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 2);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [PI_W-1:0]      lfsr_q;
  logic [PO_W-1:0]      misr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [FLUSH_W-1:0]   flush_q;
  logic                 done_q;
  logic                 pass_q;

  logic [PI_W-1:0]      lfsr_d;
  logic [PO_W-1:0]      misr_d;
  logic                 sig_match;

  // One LFSR step: shift left, feedback is the parity of the tapped bits.
  assign lfsr_d = {lfsr_q[PI_W-2:0], ^(lfsr_q & LFSR_TAPS)};

  // One MISR step: same shift/feedback structure with the CUT response folded in.
  assign misr_d = {misr_q[PO_W-2:0], ^(misr_q & MISR_TAPS)} ^ cut_po;

  // Compare the signature the MISR will hold in DONE; any X bit counts as a mismatch.
  assign sig_match = !(misr_d !== GOLDEN_SIG);

  // BIST sequencer: IDLE -> INIT -> RUN -> FLUSH -> DONE, with abort back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      misr_q  <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bistmode) begin
            state_q <= S_INIT;
          end
        end

        S_INIT: begin
          if (!bistmode) begin
            state_q <= S_IDLE;
          end else begin
            lfsr_q  <= SEED_EFF;
            misr_q  <= '0;
            cnt_q   <= '0;
            flush_q <= '0;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          if (!bistmode) begin
            state_q <= S_IDLE;
          end else begin
            misr_q <= misr_d;
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              if (FLUSH_CYCLES == 0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                pass_q  <= sig_match;
              end else begin
                state_q <= S_FLUSH;
              end
            end
          end
        end

        S_FLUSH: begin
          // The LFSR and pattern counter hold so the last responses drain into the MISR.
          if (!bistmode) begin
            state_q <= S_IDLE;
          end else begin
            misr_q  <= misr_d;
            flush_q <= flush_q + 1'b1;
            if (flush_q == FLUSH_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= sig_match;
            end
          end
        end

        S_DONE: begin
          // Signature and verdict stay frozen until the pin releases BIST mode.
          if (!bistmode) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  // The CUT is held in reset by the chip reset and for the single INIT cycle.
  assign cut_rst = rst | (state_q == S_INIT);

  // Patterns replace the pins only while BIST mode is requested and a run is active.
  assign cut_pi = (bistmode && (state_q != S_IDLE)) ? lfsr_q : pi;

  assign signature = misr_q;
  assign bistdone  = done_q;
  assign bistpass  = pass_q;

endmodule

// File: doc/bist_ctrl.md
Name: bist_ctrl

Overview:
- On-chip BIST controller for the `chip` top level, sitting between the chip pins and the CUT (`circuit`).
- In functional mode it passes the external PI straight to the CUT.
- In BIST mode it resets the CUT and drives LFSR pseudo-random patterns into the CUT's 35 inputs. It compacts the CUT's 49 outputs in a MISR and compares the final signature against a golden value.
- It produces the chip's `bistdone` and `bistpass` pins.

Parameters:
- PI_W, 35, CUT input width / LFSR width
- PO_W, 49, CUT output width / MISR width
- NUM_PATTERNS, 2000, number of LFSR patterns applied (>=1)
- FLUSH_CYCLES, 2, extra MISR capture cycles after the last pattern, with the LFSR held (>=0)
- LFSR_SEED, 35'h1, LFSR load value; all-zero is illegal and is replaced by 1
- LFSR_TAPS, (1<<34)|(1<<1), feedback mask for x^35+x^2+1
- MISR_TAPS, (1<<48)|(1<<8), feedback mask for x^49+x^9+1
- GOLDEN_SIG, 49'h0, expected fault-free signature

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- bistmode  in  1  1 = run BIST, 0 = functional mode
- pi  in  PI_W  external primary inputs
- cut_po  in  PO_W  CUT primary outputs
- cut_pi  out  PI_W  CUT primary inputs
- cut_rst  out  1  CUT reset
- signature  out  PO_W  current MISR contents, used for golden extraction
- bistdone  out  1  BIST complete
- bistpass  out  1  final signature == GOLDEN_SIG; valid while bistdone=1

Behaviour:
- Reset values (async, rst=1):
  - state=IDLE, lfsr=LFSR_SEED, misr=0, cnt=0
  - bistdone=0, bistpass=0
  - cut_rst follows rst combinationally: cut_rst = rst | (state==INIT)
- cut_pi mux (combinational): cut_pi = (bistmode && state in {INIT, RUN, FLUSH, DONE}) ? lfsr : pi.
- IDLE:
  - bistmode=1 -> INIT on the next edge
  - otherwise stay in IDLE
- INIT (1 cycle): load lfsr=LFSR_SEED, misr=0, cnt=0; cut_rst=1 -> RUN.
- RUN, every edge:
  - misr <= {misr[PO_W-2:0], ^(misr & MISR_TAPS)} ^ cut_po
  - lfsr <= {lfsr[PI_W-2:0], ^(lfsr & LFSR_TAPS)}
  - cnt <= cnt+1
  - if cnt==NUM_PATTERNS-1: go to FLUSH, or to DONE when FLUSH_CYCLES=0
- FLUSH:
  - MISR keeps updating each edge; LFSR and cnt hold
  - after FLUSH_CYCLES edges -> DONE (separate flush counter, reset in INIT)
- DONE:
  - bistdone=1 and bistpass=(misr==GOLDEN_SIG) are registered on the edge entering DONE; misr frozen
  - DONE holds until rst, or until bistmode=0, which moves to IDLE and clears bistdone and bistpass
- Latency: bistdone rises on rising edge number 2+NUM_PATTERNS+FLUSH_CYCLES after rst deasserts, provided bistmode=1 throughout.
- bistmode=0 in INIT/RUN/FLUSH: abort to IDLE on the next edge; bistdone=0, bistpass=0, no signature compare.
- rst mid-run: immediate return to reset values; a new run starts from INIT once rst falls and bistmode=1.
- cnt width: clog2(NUM_PATTERNS+1). No wrap-around is possible because exit occurs at NUM_PATTERNS-1.
- Unknown (X) bits in misr at compare must yield bistpass=0. The compare is a !== style mismatch, so X never counts as a pass.
- bistpass is never 1 while bistdone=0.

Test Plan:
- Functional passthrough: bistmode=0, pi=35'h5_5555_5555 -> cut_pi=35'h5_5555_5555, cut_rst=0, bistdone=0 indefinitely.
- LFSR sequence: NUM_PATTERNS=8, FLUSH_CYCLES=2, bistmode=1, rst pulse -> cut_pi = 1 in INIT and first RUN cycle, then 2, 5, 10 on successive edges; cut_rst=1 only in INIT.
- Fault-free pass: cut_po tied to 0, GOLDEN_SIG=0, NUM_PATTERNS=8, FLUSH_CYCLES=2 -> bistdone=1 on the 12th edge after rst falls, bistpass=1, signature=0, both held while bistmode=1.
- Detected fault: cut_po=49'h1 only during the third RUN cycle, GOLDEN_SIG=0 -> bistdone=1 on edge 12, bistpass=0, signature nonzero.
- Abort: drop bistmode at RUN cycle 4 -> IDLE next edge, bistdone=0. Raise bistmode again -> full run; bistdone on edge 12 after re-entry from IDLE.
- Back-to-back runs: repeat the rst-pulse run three times with fault-free cut_po -> identical signature and bistpass=1 each time. Assert rst while in DONE -> bistdone=0 asynchronously.
